// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locking arbiter sharing the uart_tx byte FIFO between requesters
// Ports:
//    clk, rst                               clock and asynchronous active-high reset
//    src_valid, src_data, src_last          per-source byte offer; source i's byte is at src_data[8i+7:8i]
//    src_ready                              one-cycle pulse: source's byte consumed
//    uart_start, uart_data, uart_fifo_ready enqueue strobe, byte and back-pressure of uart_tx
//    grant, busy                            one-hot current owner (zero when idle); arbiter not idle
module uart_tx_arbiter #(
   parameter int NUM_SOURCES  = 2,
   parameter int LOCK_TIMEOUT = 27000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_SOURCES-1:0]   src_valid,
   input  logic [8*NUM_SOURCES-1:0] src_data,
   input  logic [NUM_SOURCES-1:0]   src_last,
   output logic [NUM_SOURCES-1:0]   src_ready,
   output logic                     uart_start,
   output logic [7:0]               uart_data,
   input  logic                     uart_fifo_ready,
   output logic [NUM_SOURCES-1:0]   grant,
   output logic                     busy
);
   localparam int PW = $clog2(NUM_SOURCES);
   localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
   typedef enum logic [1:0] {IDLE, LOAD, STROBE, WAIT_READY} state_t;
   state_t state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d, sel;
   logic [PW:0] idx;
   logic found;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic last_q, last_d, start_q, start_d, busy_q, busy_d;
   logic [7:0] data_q, data_d;
   logic [NUM_SOURCES-1:0] ready_q, ready_d, grant_q, grant_d;
   // first valid requester after ptr, wrapping; idx is one bit wider so ptr+k never overflows before the wrap
   always_comb begin
      sel = ptr_q;
      found = 1'b0;
      idx = '0;
      for (int k = 1; k <= NUM_SOURCES; k++) begin
         idx = {1'b0, ptr_q} + (PW+1)'(k);
         if (idx >= (PW+1)'(NUM_SOURCES)) idx = idx - (PW+1)'(NUM_SOURCES);
         if (!found && src_valid[idx[PW-1:0]]) begin
            found = 1'b1;
            sel = idx[PW-1:0];
         end
      end
   end
   // ptr always holds the current owner while locked, so it doubles as the grant index
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      grant_d = grant_q;
      cnt_d = cnt_q;
      last_d = last_q;
      data_d = data_q;
      start_d = 1'b0;
      ready_d = '0;
      cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      case (state_q)
         IDLE: if (found) begin
            grant_d = '0;
            grant_d[sel] = 1'b1;
            ptr_d = sel;
            cnt_d = '0;
            state_d = LOAD;
         end
         LOAD: if (src_valid[ptr_q] && uart_fifo_ready) begin
            data_d = src_data[{ptr_q, 3'b000} +: 8];
            start_d = 1'b1;
            ready_d[ptr_q] = 1'b1;
            last_d = src_last[ptr_q];
            cnt_d = '0;
            state_d = STROBE;
         end else if (!src_valid[ptr_q]) begin
            // only an owner that stops offering data is timed out; FIFO stalls never are
            cnt_d = cnt_inc;
            if (LOCK_TIMEOUT != 0 && cnt_inc == CW'(LOCK_TIMEOUT)) begin
               grant_d = '0;
               cnt_d = '0;
               state_d = IDLE;
            end
         end
         STROBE: state_d = WAIT_READY;
         WAIT_READY: if (uart_fifo_ready) begin
            state_d = last_q ? IDLE : LOAD;
            grant_d = last_q ? '0 : grant_q;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q <= PW'(NUM_SOURCES - 1);
         grant_q <= '0;
         cnt_q <= '0;
         last_q <= 1'b0;
         data_q <= 8'h00;
         start_q <= 1'b0;
         ready_q <= '0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         grant_q <= grant_d;
         cnt_q <= cnt_d;
         last_q <= last_d;
         data_q <= data_d;
         start_q <= start_d;
         ready_q <= ready_d;
         busy_q <= busy_d;
      end
   end
   assign src_ready = ready_q;
   assign uart_start = start_q;
   assign uart_data = data_q;
   assign grant = grant_q;
   assign busy = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with four sources and an 8-cycle lock timeout
module tb_uart_tx_arbiter;
   localparam int N = 4;
   localparam int TO = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] src_valid, src_last, src_ready, grant;
   logic [8*N-1:0] src_data;
   logic uart_start, uart_fifo_ready, busy;
   logic [7:0] uart_data;
   logic bp_en = 1'b0;
   logic fifo_force = 1'b1;
   logic [8:0] sq[N][$];
   logic [9:0] exp_q[$];
   int errors = 0;
   int checks = 0;
   int mptr = N - 1;

   uart_tx_arbiter #(.NUM_SOURCES(N), .LOCK_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
      .uart_start(uart_start), .uart_data(uart_data), .uart_fifo_ready(uart_fifo_ready),
      .grant(grant), .busy(busy)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add_pkt(input int s, input int len, input logic [7:0] b0);
      for (int k = 0; k < len; k++) sq[s].push_back({k == len - 1, 8'(b0 + 8'(k))});
   endtask

   // Reference: whole packets are issued one source at a time, owners chosen
   // round-robin after the previous owner among sources that still have data.
   task automatic model_run();
      logic [8:0] rem[N][$];
      logic [8:0] b;
      int pick;
      for (int i = 0; i < N; i++) rem[i] = sq[i];
      forever begin
         pick = -1;
         for (int k = 1; k <= N; k++)
            if (pick < 0 && rem[(mptr + k) % N].size() != 0) pick = (mptr + k) % N;
         if (pick < 0) break;
         do begin
            b = rem[pick].pop_front();
            exp_q.push_back({2'(pick), b[7:0]});
         end while (!b[8] && rem[pick].size() != 0);
         mptr = pick;
      end
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      int left = 0;
      while ((exp_q.size() != 0 || busy) && n < bound) begin
         step();
         n++;
      end
      chk("drain_in_time", 32'(n < bound), 1);
      for (int i = 0; i < N; i++) left += sq[i].size();
      chk("sources_drained", left, 0);
   endtask

   task automatic wait_start(input string name);
      int n = 0;
      while (!uart_start && n < 20) begin
         step();
         n++;
      end
      chk(name, 32'(uart_start), 1);
   endtask

   // source model: presents queue heads, pops on src_ready, also drives the FIFO ready line
   initial begin
      logic [8:0] h;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++)
            if (src_ready[i] && sq[i].size() != 0) void'(sq[i].pop_front());
         for (int i = 0; i < N; i++) begin
            h = (sq[i].size() != 0) ? sq[i][0] : 9'h000;
            src_valid[i] = sq[i].size() != 0;
            src_data[8*i +: 8] = h[7:0];
            src_last[i] = h[8];
         end
         uart_fifo_ready = bp_en ? ($urandom_range(0, 3) != 0) : fifo_force;
      end
   end

   // monitor: checks every strobe against the scoreboard plus per-cycle output invariants
   initial begin
      logic f_edge, prev_start;
      logic [9:0] e;
      prev_start = 1'b0;
      forever begin
         @(posedge clk);
         f_edge = uart_fifo_ready;
         @(negedge clk);
         chk("ready_matches_start", 32'(src_ready), 32'(uart_start ? grant : '0));
         chk("busy_matches_grant", 32'(busy), 32'(|grant));
         if (uart_start) begin
            chk("no_back_to_back_start", 32'(prev_start), 0);
            chk("start_after_fifo_ready", 32'(f_edge), 1);
            chk("start_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("uart_data", 32'(uart_data), 32'(e[7:0]));
               chk("grant_owner", 32'(grant), 32'(4'b0001 << e[9:8]));
            end
         end
         prev_start = uart_start;
      end
   end

   initial begin
      int st[$];
      int cyc;
      int n;
      repeat (3) step();
      chk("rst_uart_start", 32'(uart_start), 0);
      chk("rst_uart_data", 32'(uart_data), 0);
      chk("rst_src_ready", 32'(src_ready), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      step();
      // round-robin with packet lock, 3-cycle spacing inside a packet
      mptr = N - 1;
      add_pkt(0, 3, 8'h41);
      add_pkt(0, 3, 8'h41);
      add_pkt(1, 3, 8'h61);
      add_pkt(1, 3, 8'h61);
      model_run();
      cyc = 0;
      do begin
         step();
         cyc++;
         if (uart_start) st.push_back(cyc);
      end while ((exp_q.size() != 0 || busy) && cyc < 400);
      chk("rr_start_count", st.size(), 12);
      for (int i = 1; i < st.size(); i++)
         if (i % 3 != 0) chk("in_packet_spacing", st[i] - st[i-1], 3);
      wait_idle(50);
      // back-pressure held in LOAD
      fifo_force = 1'b0;
      add_pkt(2, 3, 8'h30);
      model_run();
      n = 0;
      while (grant == '0 && n < 10) begin
         step();
         n++;
      end
      chk("bp_grant", 32'(grant), 32'b0100);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_no_start", 32'(uart_start), 0);
      end
      fifo_force = 1'b1;
      step();
      chk("bp_start_after_rise", 32'(uart_start), 1);
      wait_idle(50);
      // lock timeout: S0 stalls after a non-last byte, S1 waits
      sq[0].push_back({1'b0, 8'h10});
      add_pkt(1, 1, 8'h20);
      exp_q.push_back({2'd0, 8'h10});
      exp_q.push_back({2'd1, 8'h20});
      mptr = 1;
      wait_start("to_first_start");
      n = 0;
      while (grant != '0 && n < 30) begin
         step();
         n++;
      end
      chk("to_revoke_cycle", n, 2 + TO);
      step();
      chk("to_regrant", 32'(grant), 32'b0010);
      wait_idle(50);
      // asynchronous reset in STROBE, then release with two requesters
      add_pkt(1, 2, 8'h55);
      model_run();
      wait_start("mid_pkt_start");
      #2 rst = 1'b1;
      #1;
      chk("arst_uart_start", 32'(uart_start), 0);
      chk("arst_uart_data", 32'(uart_data), 0);
      chk("arst_src_ready", 32'(src_ready), 0);
      chk("arst_grant", 32'(grant), 0);
      chk("arst_busy", 32'(busy), 0);
      exp_q.delete();
      for (int i = 0; i < N; i++) sq[i].delete();
      add_pkt(0, 1, 8'hA0);
      add_pkt(1, 1, 8'hB0);
      mptr = N - 1;
      model_run();
      step();
      step();
      rst = 1'b0;
      step();
      chk("rel_grant", 32'(grant), 32'b0001);
      chk("rel_busy", 32'(busy), 1);
      chk("rel_no_start", 32'(uart_start), 0);
      step();
      chk("rel_first_start", 32'(uart_start), 1);
      wait_idle(50);
      // four single-byte requesters
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) add_pkt(i, 1, 8'(8'hC0 + 8'(16 * r + i)));
      model_run();
      wait_idle(100);
      // randomized packets with random FIFO back-pressure
      bp_en = 1'b1;
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 1) == 1)
               repeat ($urandom_range(1, 3)) add_pkt(i, $urandom_range(1, 4), 8'($urandom));
         model_run();
         wait_idle(2000);
      end
      bp_en = 1'b0;
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-locking arbiter that shares the single `uart_tx` byte FIFO between up to four byte-stream requesters (e.g. the SPI-slave receive path and a status/string generator). It sits between the requesters and `uart_tx` in the top level. It replaces the ad-hoc SPI→UART sequencing state machine. It issues the one-cycle `start_uart` enqueue pulse and honours `fifo_ready` back-pressure.

## Interface
- `NUM_SOURCES`, 2, number of requesters; legal range 2–4.
- `LOCK_TIMEOUT`, 27000, idle cycles a locked owner may stall before its grant is revoked. The default is 1 ms at 27 MHz. A value of 0 disables the timeout.
- `Clock`  in  1  system clock, 27 MHz.
- `Reset`  in  1  asynchronous, active-high reset.
- `src_valid`  in  NUM_SOURCES  source i has a byte on `src_data`.
- `src_data`  in  8*NUM_SOURCES  flattened bytes; source i is at `[8i+7:8i]`.
- `src_last`  in  NUM_SOURCES  the presented byte ends source i's packet.
- `src_ready`  out  NUM_SOURCES  one-cycle pulse: source i's byte was consumed.
- `uart_start`  out  1  enqueue strobe to `uart_tx.start_uart`.
- `uart_data`  out  8  byte to `uart_tx.data`.
- `uart_fifo_ready`  in  1  `uart_tx.fifo_ready`.
- `grant`  out  NUM_SOURCES  one-hot current owner; all zero when idle.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- **States:** IDLE, LOAD, STROBE, WAIT_READY.
- **IDLE:**
  - If any `src_valid` is high, select the first requester searching from `ptr+1` upward, with wrap-around.
  - Register the selection as one-hot `grant`, set `ptr` to it, and go to LOAD.
  - `ptr` resets to NUM_SOURCES-1, so source 0 wins first.
- **LOAD:**
  - If `src_valid[g]` and `uart_fifo_ready` are both high, register the following, then go to STROBE:
    - `uart_data` ← `src_data[g]`
    - `uart_start` ← 1
    - `src_ready[g]` ← 1
    - `last_flag` ← `src_last[g]`
    - timeout counter ← 0
  - If `src_valid[g]` is low, increment the timeout counter.
  - When the counter reaches LOCK_TIMEOUT (and LOCK_TIMEOUT ≠ 0), clear `grant` and go to IDLE. `ptr` keeps its value, so the others get priority.
  - If `uart_fifo_ready` is low, hold. The counter does not advance for FIFO stalls.
- **STROBE:** `uart_start` ← 0 and `src_ready` ← 0; go to WAIT_READY.
- **WAIT_READY:** wait for `uart_fifo_ready`. Then:
  - if `last_flag` is set: clear `grant` and go to IDLE;
  - otherwise: go to LOAD.
- **Packet lock:** the grant is never changed between the first byte and the `src_last` byte, except by timeout or reset.
- **Requests from other sources** arriving while locked are ignored until IDLE. No request is lost, because sources hold `src_valid`.
- **Source obligation:** `src_data`, `src_last` and `src_valid` are stable while valid and no `src_ready` is seen. A source may update them on the cycle after `src_ready`.
- **Sizing:** the timeout counter is `$clog2(LOCK_TIMEOUT+1)` bits wide and saturates; it never wraps.

## Timing
- **Reset values:**
  - `uart_start` = 0, `uart_data` = 8'h00, `src_ready` = 0, `grant` = 0, `busy` = 0.
  - state = IDLE, `ptr` = NUM_SOURCES-1, counter = 0.
- **Reset is asynchronous** and takes effect immediately, including mid-packet. No strobe may be emitted in the cycle reset deasserts.
- **All outputs are registered.**
- **Cycle latencies:**
  - Request sampled in IDLE at cycle n → `grant` and `busy` high at n+1.
  - LOAD accept at cycle m → `uart_start`, `uart_data` and `src_ready` are valid during cycle m+1 only.
  - Best-case throughput is one byte per 3 cycles: LOAD → STROBE → WAIT_READY → LOAD.
  - First byte of an idle system: 2 cycles from `src_valid` to `uart_start`.
- **Exclusivity:** `uart_start` and the single active `src_ready` bit are always asserted in the same cycle, and never in two consecutive cycles.
- **Full FIFO:** `uart_fifo_ready` low holds LOAD or WAIT_READY indefinitely, with no strobes.
- **Simultaneous requests in IDLE:** resolved strictly by round-robin order from `ptr+1`.

## Test plan
- **Reset defaults:** Reset asserted mid-packet while in STROBE → all outputs 0 immediately. After release, with `src_valid`=2'b11, `grant`=2'b01 at cycle 2.
- **Round-robin with packet lock:**
  - Stimulus: two sources each stream 3-byte packets continuously (S0 sends 0x41,0x42,0x43 with last on 0x43; S1 sends 0x61,0x62,0x63); `uart_fifo_ready`=1.
  - Required: the `uart_data` sequence at the `uart_start` pulses is 41,42,43,61,62,63,41… with no interleaving, and `uart_start` is spaced exactly 3 cycles apart within a packet.
- **Back-pressure:** `uart_fifo_ready` is forced low for 10 cycles while in LOAD → no `uart_start`. Its first rising edge yields `uart_start` exactly 1 cycle later, and no byte is dropped or duplicated.
- **Timeout:**
  - Stimulus: LOCK_TIMEOUT=8; S0 sends byte 0x10 without last, then drops `src_valid`; S1 is valid.
  - Required: after 8 LOAD cycles, `grant` goes from 01 to 00, then to 10, and S1's byte is issued next.
- **Four sources:** NUM_SOURCES=4, all sources valid with single-byte packets (`src_last`=1) → grants follow 0,1,2,3,0. Each `src_ready` pulse is one cycle wide and coincides with `uart_start`.
